// File: rtl/ts1n40lpb_2048x32_m4fwba_pkg.sv
// Shared constants for the 2048x32 single-port SRAM macro model.
package ts1n40lpb_2048x32_m4fwba_pkg;

  // Default geometry of the macro.
  localparam int DEF_WORDS = 2048;
  localparam int DEF_BITS  = 32;
  localparam int DEF_AW    = 11;

  // Value every bit of the Q register takes on reset (Q clears to all zeros).
  localparam logic Q_RST_BIT = 1'b0;

endpackage

// File: rtl/ts1n40lpb_2048x32_m4fwba_sram_port_mux.sv
// Selects between the normal and BIST access bundles; purely combinational
// so a BIST change only matters at the next sampling edge.
module sram_port_mux #(
  parameter int AW   = 11,
  parameter int BITS = 32
) (
  input  logic            bist_i,
  input  logic            ceb_i,
  input  logic            web_i,
  input  logic [AW-1:0]   a_i,
  input  logic [BITS-1:0] d_i,
  input  logic [BITS-1:0] bweb_i,
  input  logic            cebm_i,
  input  logic            webm_i,
  input  logic [AW-1:0]   am_i,
  input  logic [BITS-1:0] dm_i,
  input  logic [BITS-1:0] bwebm_i,
  output logic            ce_n_o,
  output logic            we_n_o,
  output logic [AW-1:0]   addr_o,
  output logic [BITS-1:0] din_o,
  output logic [BITS-1:0] bwe_n_o
);

  // Route the selected bundle to the array side.
  always_comb begin
    ce_n_o  = ceb_i;
    we_n_o  = web_i;
    addr_o  = a_i;
    din_o   = d_i;
    bwe_n_o = bweb_i;
    if (bist_i) begin
      ce_n_o  = cebm_i;
      we_n_o  = webm_i;
      addr_o  = am_i;
      din_o   = dm_i;
      bwe_n_o = bwebm_i;
    end
  end

endmodule

// File: rtl/ts1n40lpb_2048x32_m4fwba.sv
// 2048x32 single-port SRAM model: per-bit masked write, power-down,
// BIST port select, registered read and asynchronous write-through bypass.
module ts1n40lpb_2048x32_m4fwba
  import ts1n40lpb_2048x32_m4fwba_pkg::*;
#(
  parameter int WORDS = DEF_WORDS,
  parameter int BITS  = DEF_BITS,
  parameter int AW    = DEF_AW
) (
  input  logic            CLK,
  input  logic            RSTB,
  input  logic            PD,
  input  logic            CEB,
  input  logic            WEB,
  input  logic [AW-1:0]   A,
  input  logic [BITS-1:0] D,
  input  logic [BITS-1:0] BWEB,
  input  logic            CEBM,
  input  logic            WEBM,
  input  logic [AW-1:0]   AM,
  input  logic [BITS-1:0] DM,
  input  logic [BITS-1:0] BWEBM,
  input  logic            BIST,
  input  logic            AWT,
  input  logic [1:0]      RTSEL,
  input  logic [1:0]      WTSEL,
  output logic [BITS-1:0] Q
);

  logic            ce_n;
  logic            we_n;
  logic [AW-1:0]   addr;
  logic [BITS-1:0] din;
  logic [BITS-1:0] bwe_n;

  logic [BITS-1:0] mem_q [WORDS];
  logic [BITS-1:0] q_q;
  logic [BITS-1:0] q_d;
  logic            access;

  // Timing trims exist only for pin compatibility with the hard macro.
  logic unused_trim;
  assign unused_trim = ^{RTSEL, WTSEL};

  sram_port_mux #(
    .AW   (AW),
    .BITS (BITS)
  ) u_port_mux (
    .bist_i  (BIST),
    .ceb_i   (CEB),
    .web_i   (WEB),
    .a_i     (A),
    .d_i     (D),
    .bweb_i  (BWEB),
    .cebm_i  (CEBM),
    .webm_i  (WEBM),
    .am_i    (AM),
    .dm_i    (DM),
    .bwebm_i (BWEBM),
    .ce_n_o  (ce_n),
    .we_n_o  (we_n),
    .addr_o  (addr),
    .din_o   (din),
    .bwe_n_o (bwe_n)
  );

  // An edge performs an access only out of reset, powered up and enabled.
  assign access = RSTB & ~PD & ~ce_n;

  // Q register next state: load on a read access, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (access && we_n) begin
      q_d = mem_q[addr];
    end
  end

  // Q register with asynchronous clear; the array itself is never reset.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      q_q <= {BITS{Q_RST_BIT}};
    end else begin
      q_q <= q_d;
    end
  end

  // Masked write: only bits whose active-low enable is 0 take new data.
  always_ff @(posedge CLK) begin
    if (access && !we_n) begin
      for (int i = 0; i < BITS; i++) begin
        if (!bwe_n[i]) begin
          mem_q[addr][i] <= din[i];
        end
      end
    end
  end

  // Write-through bypass shows the selected input data without a clock.
  assign Q = AWT ? din : q_q;

endmodule

// File: tb/tb_ts1n40lpb_2048x32_m4fwba.sv
// Self-checking bench: directed scenarios followed by randomized traffic,
// all checked against a word-level memory model kept in the bench.
module tb_ts1n40lpb_2048x32_m4fwba;

  logic        clk = 1'b0;
  logic        rstb, pd, ceb, web, cebm, webm, bist, awt;
  logic [10:0] a, am;
  logic [31:0] d, bweb, dm, bwebm, q;
  logic [1:0]  rtsel, wtsel;

  // Reference model: word contents plus which bits have ever been written.
  logic [31:0] mm [2048];
  logic [31:0] kn [2048];
  logic [31:0] q_exp;
  bit          q_ok;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ts1n40lpb_2048x32_m4fwba dut (
    .CLK   (clk),
    .RSTB  (rstb),
    .PD    (pd),
    .CEB   (ceb),
    .WEB   (web),
    .A     (a),
    .D     (d),
    .BWEB  (bweb),
    .CEBM  (cebm),
    .WEBM  (webm),
    .AM    (am),
    .DM    (dm),
    .BWEBM (bwebm),
    .BIST  (bist),
    .AWT   (awt),
    .RTSEL (rtsel),
    .WTSEL (wtsel),
    .Q     (q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One clock edge: note the effective port before the edge, advance the
  // model by the access rules, then compare Q just after the edge.
  task automatic cycle(input string tag);
    logic        e_ce, e_we;
    logic [10:0] e_a;
    logic [31:0] e_d, e_m;
    e_ce = bist ? cebm  : ceb;
    e_we = bist ? webm  : web;
    e_a  = bist ? am    : a;
    e_d  = bist ? dm    : d;
    e_m  = bist ? bwebm : bweb;
    @(posedge clk);
    #1;
    if (!rstb) begin
      q_exp = 32'h0;
      q_ok  = 1'b1;
    end else if (!pd && !e_ce) begin
      if (e_we) begin
        q_exp = mm[e_a];
        q_ok  = (kn[e_a] == 32'hFFFF_FFFF);
      end else begin
        for (int i = 0; i < 32; i++)
          if (!e_m[i]) mm[e_a][i] = e_d[i];
        kn[e_a] = kn[e_a] | ~e_m;
      end
    end
    if (awt)
      check({tag, "_awt"}, q, bist ? dm : d);
    else if (q_ok)
      check(tag, q, q_exp);
  endtask

  task automatic idle();
    ceb = 1'b1; web = 1'b1; cebm = 1'b1; webm = 1'b1;
  endtask

  task automatic wr(input logic [10:0] addr, input logic [31:0] data, input logic [31:0] mask);
    bist = 1'b0; ceb = 1'b0; web = 1'b0; a = addr; d = data; bweb = mask;
    cycle("wr");
    idle();
  endtask

  task automatic rd(input logic [10:0] addr);
    bist = 1'b0; ceb = 1'b0; web = 1'b1; a = addr;
    cycle("rd");
    idle();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mm[i] = 'x;
      kn[i] = 32'h0;
    end
    rstb = 1'b0; pd = 1'b0; bist = 1'b0; awt = 1'b0;
    ceb = 1'b1; web = 1'b1; a = '0; d = '0; bweb = '1;
    cebm = 1'b1; webm = 1'b1; am = '0; dm = '0; bwebm = '1;
    rtsel = 2'd1; wtsel = 2'd2;
    q_exp = 32'h0; q_ok = 1'b1;

    // Reset clears Q.
    #3;
    check("reset_q", q, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    repeat (3) cycle("idle_after_reset");

    // Basic write/read and back-to-back reads.
    wr(11'd5, 32'hDEAD_BEEF, 32'h0);
    rd(11'd5);
    check("rd_a5", q, 32'hDEAD_BEEF);
    wr(11'd0, 32'h1, 32'h0);
    wr(11'd1, 32'h2, 32'h0);
    wr(11'd2, 32'h3, 32'h0);
    ceb = 1'b0; web = 1'b1;
    a = 11'd0; cycle("b2b0"); check("b2b_q0", q, 32'h1);
    a = 11'd1; cycle("b2b1"); check("b2b_q1", q, 32'h2);
    a = 11'd2; cycle("b2b2"); check("b2b_q2", q, 32'h3);
    idle();

    // Per-bit mask.
    wr(11'd7, 32'hFFFF_FFFF, 32'h0);
    wr(11'd7, 32'h0, 32'hFFFF_0000);
    rd(11'd7);
    check("mask_a7", q, 32'hFFFF_0000);

    // BIST port: normal-port stimulus must be ignored while BIST=1.
    wr(11'd9, 32'h0, 32'h0);
    bist = 1'b1;
    ceb = 1'b0; web = 1'b0; a = 11'h7FF; d = 32'h0000_0BAD; bweb = 32'h0;
    cebm = 1'b0; webm = 1'b0; am = 11'h7FF; dm = 32'h1234_5678; bwebm = 32'h0;
    cycle("bist_wr");
    cebm = 1'b1; a = 11'd9;
    cycle("bist_idle");
    bist = 1'b0;
    idle();
    rd(11'h7FF);
    check("bist_a7ff", q, 32'h1234_5678);
    rd(11'd9);
    check("bist_a9", q, 32'h0);

    // Power-down suppresses writes and reads; Q holds.
    wr(11'd3, 32'h0, 32'h0);
    rd(11'd5);
    pd = 1'b1;
    ceb = 1'b0; web = 1'b0; a = 11'd3; d = 32'hAAAA_5555; bweb = 32'h0;
    cycle("pd_wr");
    check("pd_q_hold", q, 32'hDEAD_BEEF);
    web = 1'b1;
    cycle("pd_rd");
    pd = 1'b0;
    idle();
    rd(11'd3);
    check("pd_a3", q, 32'h0);

    // Write-through bypass without a clock edge.
    awt = 1'b1; d = 32'hCAFE_F00D;
    #2;
    check("awt_bypass", q, 32'hCAFE_F00D);
    awt = 1'b0;
    #1;
    check("awt_release", q, 32'h0);

    // Reset in the middle of a write cycle.
    rd(11'd5);
    ceb = 1'b0; web = 1'b0; a = 11'd5; d = 32'h0; bweb = 32'h0;
    #2;
    rstb = 1'b0;
    #1;
    q_exp = 32'h0; q_ok = 1'b1;
    check("async_rst_q", q, 32'h0);
    cycle("rst_wr_discard");
    #3;
    rstb = 1'b1;
    idle();
    rd(11'd5);
    check("rst_wr_a5", q, 32'hDEAD_BEEF);

    // Randomized traffic over a small hot address set plus occasional far ones.
    for (int i = 0; i < 16; i++) wr(11'(i), $urandom, 32'h0);
    for (int n = 0; n < 600; n++) begin
      bist  = ($urandom_range(0, 3) == 0);
      pd    = ($urandom_range(0, 7) == 0);
      awt   = ($urandom_range(0, 9) == 0);
      ceb   = ($urandom_range(0, 4) == 0);
      cebm  = ($urandom_range(0, 4) == 0);
      web   = $urandom_range(0, 1) == 1;
      webm  = $urandom_range(0, 1) == 1;
      a     = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
      am    = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
      d     = $urandom;
      dm    = $urandom;
      case ($urandom_range(0, 2))
        0:       bweb = 32'h0;
        1:       bweb = $urandom;
        default: bweb = 32'hFFFF_FFFF;
      endcase
      case ($urandom_range(0, 2))
        0:       bwebm = 32'h0;
        1:       bwebm = $urandom;
        default: bwebm = 32'hFFFF_FFFF;
      endcase
      cycle("rand");
    end
    awt = 1'b0; pd = 1'b0; bist = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
